spi_bus_scheduler: RTL and testbench
====================================

# spi_bus_scheduler

SPI mode-0 bus master that shares one SCLK/MOSI/MISO bus among `NUM_REQ` requesters, each owning one slave on its own active-low chip select. The block arbitrates, generates SCLK from the system clock, sequences chip select and shifts one 8-bit full-duplex byte MSB-first per grant. It sits between on-chip requesters and the SPI slave devices, one `cs[i]` per slave.

## Interface
- `NUM_REQ`, 2: number of requesters / slaves (2..8).
- `CLK_DIV`, 4: system clocks per SCLK half-period (≥2).
- `CS_IDLE`, 2: minimum cycles with all `cs` high between transfers (≥1).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `req`  in  NUM_REQ  per-requester transfer request, held until `done` with matching `grant`.
- `tx_data`  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- `grant`  out  NUM_REQ  one-hot owner of the current transfer; 0 when idle.
- `done`  out  1  one-cycle pulse at end of transfer.
- `rx_data`  out  8  byte received from MISO; valid with `done`, held until the next `done`.
- `busy`  out  1  high from grant through the end of the CS_IDLE gap.
- `sclk`  out  1  SPI clock, idle low.
- `cs`  out  NUM_REQ  active-low chip selects.
- `mosi`  out  1  master out, MSB first.
- `miso`  in  1  master in; tri-stated by slaves when deselected.

## Operation
- FSM: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE: if any `req` is high, pick the winner, latch its `tx_data` byte into the shift register and go to SETUP. Next cycle: `grant[w]`=1, `cs[w]`=0, `busy`=1, `mosi`=byte[7].
- SETUP: wait CLK_DIV cycles with `sclk` low, then go to XFER.
- XFER: `sclk` toggles every CLK_DIV cycles for 16 edges.
  - On each rising edge, sample `miso` into the receive shift register LSB (MSB-first assembly).
  - On each falling edge, shift `mosi` to the next bit. After the 8th falling edge, `mosi`=0.
- HOLD: CLK_DIV cycles with `sclk` low and `cs[w]` still low.
- Leaving HOLD:
  - `cs` all high, `grant`=0.
  - `done` pulses 1 cycle, and `rx_data` updates in the same cycle.
  - Go to GAP.
- GAP: CS_IDLE cycles, `busy` high. Then go to IDLE; arbitration is evaluated that same IDLE cycle.
- Arbitration: round-robin. The pointer moves to one past the last winner, and lowest index wins at reset.
- `req` falling mid-transfer does not abort; the transfer completes and `done` still pulses.
- `tx_data` is sampled only in the IDLE winning cycle; later changes are ignored.
- Only one `cs` bit is ever low. `mosi`=0 whenever all `cs` are high.

## Timing
- Winning IDLE cycle is T0.
  - `cs[w]` is low from T0+1 through T0+18·CLK_DIV.
  - `done` and `rx_data` appear at T0+18·CLK_DIV+1.
- First SCLK rise is at T0+1+CLK_DIV. Rises are spaced 2·CLK_DIV apart, and there are exactly 8 rises and 8 falls per transfer.
- MOSI is stable for CLK_DIV cycles on both sides of every rising edge.
- Back-to-back requests: next winning IDLE cycle is T0+18·CLK_DIV+CS_IDLE+1.
- Reset values: `sclk`=0, `cs`=all 1, `mosi`=0, `grant`=0, `done`=0, `busy`=0, `rx_data`=0, RR pointer=0, FSM=IDLE.
- Reset asserted mid-transfer: all outputs return to reset values on the next clock edge, with no `done`. Slaves see `cs` rise and a truncated frame.
- `req` asserted during GAP is served at the following IDLE. No request is lost while held.

## Configuration
- `SPI_SCHED_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, lowest index always wins and no pointer register is built. A continuously held `req[0]` may starve higher indices.

## Test plan
- NUM_REQ=2, CLK_DIV=2: `req[0]` with tx 0xA5, slave model returns 0x3C → slave receives 0xA5, `rx_data`=0x3C at T0+37, `cs[0]` low exactly 36 cycles, 8 SCLK rises, `cs[1]` never low.
- `req[0]` and `req[1]` rise together and are held (tx 0x11/0x22), RR enabled → `grant` order 0,1,0,1; gap between `cs` high and next `cs` low ≥ CS_IDLE cycles.
- Same stimulus with `SPI_SCHED_RR_EN` undefined → requester 0 granted every time, `grant[1]` never asserts.
- `rst` pulsed at T0+10 during XFER → next cycle `sclk`=0, `cs`=2'b11, `busy`=0, no `done`. A new request afterwards transfers 0x5A correctly.
- `req[1]` dropped at T0+5 → transfer completes, `done` pulses once, and IDLE with no new grant follows.
- `tx_data` changed from 0xF0 to 0x0F at T0+3 → slave receives 0xF0.

Source files
------------

// File: rtl/spi_bus_scheduler.sv
// -----------------------------------------------------------------------------
// spi_bus_scheduler
//
// SPI mode-0 master shared by NUM_REQ requesters. Each requester owns one
// slave on its own active-low chip select. One 8-bit full-duplex byte is
// shifted MSB-first per grant. SCLK is derived from the system clock.
//
// Optional feature macro: SPI_SCHED_RR_EN
//   defined   -> round-robin arbitration, pointer moves to one past the winner
//   undefined -> fixed priority, lowest requesting index always wins
//
// Parameters
//   NUM_REQ  number of requesters / slaves (2..8)
//   CLK_DIV  system clocks per SCLK half-period (>=2)
//   CS_IDLE  minimum cycles with every cs high between transfers (>=1)
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset
//   i_req      per-requester request, held until o_done with matching grant
//   i_tx_data  byte for requester i at [8i+7:8i]
//   o_grant    one-hot owner of the current transfer, 0 when idle
//   o_done     one-cycle pulse at end of transfer
//   o_rx_data  byte received from MISO, valid with o_done, held until next
//   o_busy     high from grant through the end of the idle gap
//   o_sclk     SPI clock, idle low
//   o_cs       active-low chip selects
//   o_mosi     master out, MSB first, 0 whenever no slave is selected
//   i_miso     master in
// -----------------------------------------------------------------------------
module spi_bus_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_tx_data,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_done,
  output logic [7:0]             o_rx_data,
  output logic                   o_busy,
  output logic                   o_sclk,
  output logic [NUM_REQ-1:0]     o_cs,
  output logic                   o_mosi,
  input  logic                   i_miso
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [4:0]         r_edge, w_edge_nxt;   // SCLK edges issued this frame
  logic [7:0]         r_tx, w_tx_nxt;       // MSB drives MOSI; zero once drained
  logic [7:0]         r_rx, w_rx_nxt;
  logic [7:0]         r_rx_data, w_rx_data_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_cs;
  logic               r_done, w_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_sclk, w_sclk_nxt;
  logic               w_win_valid;
  logic [IW-1:0]      w_win_idx;

`ifdef SPI_SCHED_RR_EN
  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_cand;

  // Round-robin search: first requester at or after the pointer, wrapping
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand      = {1'b0, r_ptr} + (IW+1)'(k);
      w_cand      = (w_cand >= (IW+1)'(NUM_REQ)) ? (w_cand - (IW+1)'(NUM_REQ)) : w_cand;
      w_win_idx   = (!w_win_valid && i_req[w_cand[IW-1:0]]) ? w_cand[IW-1:0] : w_win_idx;
      w_win_valid = w_win_valid | i_req[w_cand[IW-1:0]];
    end
  end

  // Pointer moves to one past the winner whenever a grant is issued
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (r_state == S_IDLE && w_win_valid) begin
      r_ptr <= (w_win_idx == IW'(NUM_REQ - 1)) ? '0 : (w_win_idx + IW'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  // Fixed priority: scan downward so the lowest requesting index wins
  always_comb begin
    w_win_valid = |i_req;
    w_win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_win_idx = i_req[k] ? IW'(k) : w_win_idx;
    end
  end
`endif

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_edge_nxt    = r_edge;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;
    w_grant_nxt   = r_grant;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = r_busy;
    w_sclk_nxt    = r_sclk;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
          w_tx_nxt    = i_tx_data[{w_win_idx, 3'b000} +: 8];
          w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_cnt == DIV_LAST) begin
          // First rising edge: capture the bit the slave presented at CS fall
          w_state_nxt = S_XFER;
          w_cnt_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_edge_nxt  = 5'd1;
          w_rx_nxt    = {r_rx[6:0], i_miso};
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_XFER: begin
        if (r_cnt != DIV_LAST) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else if (r_edge == 5'd16) begin
          // Final low half-period has elapsed after the 8th fall
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          w_edge_nxt = r_edge + 5'd1;
          if (r_sclk) begin
            w_tx_nxt = {r_tx[6:0], 1'b0};
          end else begin
            w_rx_nxt = {r_rx[6:0], i_miso};
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == DIV_LAST) begin
          w_state_nxt   = S_GAP;
          w_cnt_nxt     = '0;
          w_grant_nxt   = '0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_tx_nxt    = 8'h00;
      end
    endcase
  end

  // State and output registers; reset truncates any frame without a done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_edge    <= 5'd0;
      r_tx      <= 8'h00;
      r_rx      <= 8'h00;
      r_rx_data <= 8'h00;
      r_grant   <= '0;
      r_cs      <= '1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_sclk    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_edge    <= w_edge_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_grant   <= w_grant_nxt;
      r_cs      <= ~w_grant_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_sclk    <= w_sclk_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;
  assign o_busy    = r_busy;
  assign o_sclk    = r_sclk;
  assign o_cs      = r_cs;
  assign o_mosi    = r_tx[7];

endmodule

// File: tb/tb_spi_bus_scheduler.sv
`timescale 1ns/1ps
module tb_spi_bus_scheduler;
  localparam int NUM_REQ = 2;
  localparam int CLK_DIV = 2;
  localparam int CS_IDLE = 2;
  localparam int FRAME   = 18 * CLK_DIV;
  localparam int SPACING = 18 * CLK_DIV + CS_IDLE + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] tx_data;
  logic        miso;
  logic [1:0]  grant;
  logic        done;
  logic [7:0]  rx_data;
  logic        busy;
  logic        sclk;
  logic [1:0]  cs;
  logic        mosi;

  spi_bus_scheduler #(.NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_tx_data(tx_data),
    .o_grant(grant), .o_done(done), .o_rx_data(rx_data), .o_busy(busy),
    .o_sclk(sclk), .o_cs(cs), .o_mosi(mosi), .i_miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] rx;
    logic [7:0] slv;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // slave models and bus monitor state
  logic       mon_en = 1'b0;
  logic [7:0] slv_tx [2];
  logic [7:0] slv_sh [2];
  logic [7:0] slv_rcv[2];
  int rises[2], falls[2], cs_low[2], frames[2];
  int fall_cyc, last_sel, done_cnt, done_cyc;
  int multi_cs_err, mosi_idle_err, grant_cs_err, busy_err;
  logic [1:0] prev_cs;
  logic       prev_sclk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // slave devices plus bus monitor, evaluated away from the active edge
  initial begin
    prev_cs = 2'b11; prev_sclk = 1'b0; miso = 1'b0;
    fall_cyc = 0; last_sel = -1; done_cnt = 0; done_cyc = 0;
    multi_cs_err = 0; mosi_idle_err = 0; grant_cs_err = 0; busy_err = 0;
    for (int s = 0; s < 2; s++) begin
      slv_sh[s] = 8'h00; slv_rcv[s] = 8'h00;
      rises[s] = 0; falls[s] = 0; cs_low[s] = 0; frames[s] = 0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (done === 1'b1) begin
          done_cnt = done_cnt + 1;
          done_cyc = cyc;
        end
        for (int s = 0; s < 2; s++) begin
          if (cs[s] === 1'b0 && prev_cs[s] === 1'b1) begin
            slv_sh[s] = slv_tx[s]; slv_rcv[s] = 8'h00;
            rises[s] = 0; falls[s] = 0; cs_low[s] = 0;
            frames[s] = frames[s] + 1; fall_cyc = cyc; last_sel = s;
          end
          if (cs[s] === 1'b0) begin
            cs_low[s] = cs_low[s] + 1;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
              slv_rcv[s] = {slv_rcv[s][6:0], mosi};
              rises[s] = rises[s] + 1;
            end
            if (sclk === 1'b0 && prev_sclk === 1'b1) begin
              slv_sh[s] = {slv_sh[s][6:0], 1'b0};
              falls[s] = falls[s] + 1;
            end
          end
        end
        miso = (cs[0] === 1'b0) ? slv_sh[0][7] : ((cs[1] === 1'b0) ? slv_sh[1][7] : 1'b0);
        if (cs === 2'b00) multi_cs_err = multi_cs_err + 1;
        if (cs === 2'b11 && mosi !== 1'b0) mosi_idle_err = mosi_idle_err + 1;
        if (grant !== ~cs) grant_cs_err = grant_cs_err + 1;
        if (cs !== 2'b11 && busy !== 1'b1) busy_err = busy_err + 1;
      end
      prev_cs = cs;
      prev_sclk = sclk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_cs_low(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (cs[s] === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; tx_data = 16'h0000;
    slv_tx[0] = 8'h00; slv_tx[1] = 8'h00;
    repeat (3) step();
    mon_en = 1'b1;
    total++; if (sclk !== 1'b0)     begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    total++; if (cs !== 2'b11)      begin bad++; $display("FAIL reset_cs: got %b want 11", cs); end
    total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    total++; if (grant !== 2'b00)   begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit ok; exp_t e; int f1;
    f1 = frames[1];
    slv_tx[0] = 8'h3C; tx_data[7:0] = 8'hA5;
    exp_q.push_back('{0, 8'h3C, 8'hA5});
    req = 2'b01;
    wait_done(120, ok);
    req = 2'b00;
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    e = exp_q.pop_front();
    total++; if (rx_data !== e.rx)       begin bad++; $display("FAIL basic_rx: got %h want %h", rx_data, e.rx); end
    total++; if (slv_rcv[0] !== e.slv)   begin bad++; $display("FAIL basic_slave_rx: got %h want %h", slv_rcv[0], e.slv); end
    total++; if (last_sel !== e.idx)     begin bad++; $display("FAIL basic_owner: got %0d want %0d", last_sel, e.idx); end
    total++; if (done_cyc - fall_cyc !== FRAME) begin bad++; $display("FAIL basic_latency: got %0d want %0d", done_cyc - fall_cyc, FRAME); end
    total++; if (cs_low[0] !== FRAME)    begin bad++; $display("FAIL basic_cs_low: got %0d want %0d", cs_low[0], FRAME); end
    total++; if (rises[0] !== 8)         begin bad++; $display("FAIL basic_rises: got %0d want 8", rises[0]); end
    total++; if (falls[0] !== 8)         begin bad++; $display("FAIL basic_falls: got %0d want 8", falls[0]); end
    total++; if (frames[1] !== f1)       begin bad++; $display("FAIL basic_cs1: got %0d want %0d", frames[1], f1); end
    step();
    total++; if (done !== 1'b0)          begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    total++; if (rx_data !== e.rx)       begin bad++; $display("FAIL basic_rx_hold: got %h want %h", rx_data, e.rx); end
    repeat (5) step();
  endtask

  task automatic test_back_to_back();
    bit ok; exp_t e; int f1, prev_fall, exp_ones;
    int order[4];
`ifdef SPI_SCHED_RR_EN
    order = '{0, 1, 0, 1};
    exp_ones = 2;
`else
    order = '{0, 0, 0, 0};
    exp_ones = 0;
`endif
    rst = 1'b1;
    tx_data = 16'h2211; slv_tx[0] = 8'hC3; slv_tx[1] = 8'h96;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{order[i], (order[i] == 1) ? 8'h96 : 8'hC3, (order[i] == 1) ? 8'h22 : 8'h11});
    end
    step(); step();
    f1 = frames[1];
    prev_fall = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_done(120, ok);
      if (i == 3) req = 2'b00;
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got no done want done %0d", i); end
      e = exp_q.pop_front();
      total++; if (last_sel !== e.idx)       begin bad++; $display("FAIL b2b_order: got %0d want %0d", last_sel, e.idx); end
      total++; if (rx_data !== e.rx)         begin bad++; $display("FAIL b2b_rx: got %h want %h", rx_data, e.rx); end
      total++; if (slv_rcv[e.idx] !== e.slv) begin bad++; $display("FAIL b2b_slave_rx: got %h want %h", slv_rcv[e.idx], e.slv); end
      if (i > 0) begin
        total++; if (fall_cyc - prev_fall !== SPACING) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", fall_cyc - prev_fall, SPACING); end
      end
      prev_fall = fall_cyc;
    end
    total++; if (frames[1] - f1 !== exp_ones) begin bad++; $display("FAIL b2b_grant1: got %0d want %0d", frames[1] - f1, exp_ones); end
    repeat (6) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_req_drop();
    bit ok; exp_t e; int d0, f0, f1;
    slv_tx[1] = 8'h4D; tx_data[15:8] = 8'h3E;
    exp_q.push_back('{1, 8'h4D, 8'h3E});
    req = 2'b10;
    wait_cs_low(1, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_start: got no cs want cs1 low"); end
    repeat (4) step();
    req = 2'b00;
    wait_done(120, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_timeout: got no done want done"); end
    e = exp_q.pop_front();
    total++; if (rx_data !== e.rx)       begin bad++; $display("FAIL drop_rx: got %h want %h", rx_data, e.rx); end
    total++; if (slv_rcv[1] !== e.slv)   begin bad++; $display("FAIL drop_slave_rx: got %h want %h", slv_rcv[1], e.slv); end
    total++; if (last_sel !== e.idx)     begin bad++; $display("FAIL drop_owner: got %0d want %0d", last_sel, e.idx); end
    d0 = done_cnt; f0 = frames[0]; f1 = frames[1];
    repeat (60) step();
    total++; if (done_cnt !== d0)        begin bad++; $display("FAIL drop_extra_done: got %0d want %0d", done_cnt, d0); end
    total++; if (frames[0] + frames[1] !== f0 + f1) begin bad++; $display("FAIL drop_regrant: got %0d want %0d", frames[0] + frames[1], f0 + f1); end
    total++; if (grant !== 2'b00)        begin bad++; $display("FAIL drop_grant: got %b want 00", grant); end
  endtask

  task automatic test_tx_sample();
    bit ok; exp_t e;
    slv_tx[0] = 8'hE7; tx_data[7:0] = 8'hF0;
    exp_q.push_back('{0, 8'hE7, 8'hF0});
    req = 2'b01;
    wait_cs_low(0, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL txs_start: got no cs want cs0 low"); end
    repeat (2) step();
    tx_data[7:0] = 8'h0F;
    wait_done(120, ok);
    req = 2'b00;
    total++; if (!ok) begin bad++; $display("FAIL txs_timeout: got no done want done"); end
    e = exp_q.pop_front();
    total++; if (slv_rcv[0] !== e.slv) begin bad++; $display("FAIL txs_slave_rx: got %h want %h", slv_rcv[0], e.slv); end
    total++; if (rx_data !== e.rx)     begin bad++; $display("FAIL txs_rx: got %h want %h", rx_data, e.rx); end
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    bit ok; exp_t e; int d0;
    slv_tx[0] = 8'h55; tx_data[7:0] = 8'h77;
    req = 2'b01;
    wait_cs_low(0, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_start: got no cs want cs0 low"); end
    repeat (9) step();
    d0 = done_cnt;
    rst = 1'b1; req = 2'b00;
    step();
    total++; if (sclk !== 1'b0)     begin bad++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    total++; if (cs !== 2'b11)      begin bad++; $display("FAIL rmid_cs: got %b want 11", cs); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rmid_done: got %b want 0", done); end
    total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL rmid_mosi: got %b want 0", mosi); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rx: got %h want 00", rx_data); end
    rst = 1'b0;
    repeat (50) step();
    total++; if (done_cnt !== d0)   begin bad++; $display("FAIL rmid_no_done: got %0d want %0d", done_cnt, d0); end
    slv_tx[0] = 8'h81; tx_data[7:0] = 8'h5A;
    exp_q.push_back('{0, 8'h81, 8'h5A});
    req = 2'b01;
    wait_done(120, ok);
    req = 2'b00;
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout: got no done want done"); end
    e = exp_q.pop_front();
    total++; if (slv_rcv[0] !== e.slv) begin bad++; $display("FAIL rmid_slave_rx: got %h want %h", slv_rcv[0], e.slv); end
    total++; if (rx_data !== e.rx)     begin bad++; $display("FAIL rmid_rx_after: got %h want %h", rx_data, e.rx); end
    repeat (5) step();
  endtask

  task automatic test_bus_invariants();
    total++; if (multi_cs_err !== 0)  begin bad++; $display("FAIL inv_multi_cs: got %0d want 0", multi_cs_err); end
    total++; if (mosi_idle_err !== 0) begin bad++; $display("FAIL inv_mosi_idle: got %0d want 0", mosi_idle_err); end
    total++; if (grant_cs_err !== 0)  begin bad++; $display("FAIL inv_grant_cs: got %0d want 0", grant_cs_err); end
    total++; if (busy_err !== 0)      begin bad++; $display("FAIL inv_busy: got %0d want 0", busy_err); end
    total++; if (exp_q.size() !== 0)  begin bad++; $display("FAIL inv_scoreboard: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_req_drop();
    test_tx_sample();
    test_reset_mid();
    test_bus_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
